// File: rtl/gray_to_johnson_stepper.sv
// Positions a 4-bit, 8-state Johnson register at a Gray-coded target,
// one legal Johnson transition per step, shortest-path or forward-only.
module gray_to_johnson_stepper #(
    parameter string       STEP_MODE = "SHORTEST",
    parameter int unsigned DWELL     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] gray_in,
    output logic [3:0] johnson_out,
    output logic [2:0] gray_out,
    output logic       busy,
    output logic       dir,
    output logic       done
);

    localparam bit         FWD_ONLY = (STEP_MODE == "FORWARD");
    localparam logic [3:0] DWELL_M1 = (DWELL > 0) ? 4'(DWELL - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT} state_t;

    function automatic logic [2:0] j2p(input logic [3:0] j);
        logic [2:0] p;
        case (j)
            4'b0000: p = 3'd0;
            4'b0001: p = 3'd1;
            4'b0011: p = 3'd2;
            4'b0111: p = 3'd3;
            4'b1111: p = 3'd4;
            4'b1110: p = 3'd5;
            4'b1100: p = 3'd6;
            4'b1000: p = 3'd7;
            default: p = 3'd0;
        endcase
        return p;
    endfunction

    function automatic logic [2:0] g2p(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    state_t     r_state;
    logic [3:0] r_j;
    logic [2:0] r_tgt;
    logic       r_dir;
    logic       r_done;
    logic       r_busy;
    logic       r_ready;
    logic       r_zero;
    logic [3:0] r_cnt;

    logic [2:0] w_cur_p;
    logic [2:0] w_tgt_p;
    logic [2:0] w_fwd;
    logic       w_dir_new;
    logic [3:0] w_next_j;
    logic [2:0] w_next_p;

    assign w_cur_p   = j2p(r_j);
    assign w_tgt_p   = g2p(gray_in);
    // Modulo-8 distance going forward; wraps naturally in 3 bits.
    assign w_fwd     = w_tgt_p - w_cur_p;
    assign w_dir_new = FWD_ONLY || (w_fwd <= 3'd4);
    assign w_next_j  = r_dir ? {r_j[2:0], ~r_j[3]} : {~r_j[0], r_j[3:1]};
    assign w_next_p  = j2p(w_next_j);

    assign johnson_out = r_j;
    assign gray_out    = w_cur_p ^ (w_cur_p >> 1);
    assign busy        = r_busy;
    assign in_ready    = r_ready;
    assign dir         = r_dir;
    assign done        = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_j     <= 4'b0000;
            r_tgt   <= 3'd0;
            r_dir   <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_zero  <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_done <= 1'b0;
            r_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A zero-distance command completes one cycle after acceptance.
                    if (r_zero) r_done <= 1'b1;
                    if (in_valid && r_ready) begin
                        if (w_fwd == 3'd0) begin
                            r_zero <= 1'b1;
                        end else begin
                            r_tgt   <= w_tgt_p;
                            r_dir   <= w_dir_new;
                            r_state <= S_STEP;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_STEP: begin
                    r_j <= w_next_j;
                    if (w_next_p == r_tgt) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else if (DWELL > 0) begin
                        r_state <= S_WAIT;
                        r_cnt   <= DWELL_M1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_STEP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_to_johnson_stepper.sv
// Bench for gray_to_johnson_stepper: three instances (shortest, forward-only,
// shortest with dwell 2) checked against a per-cycle expected-trajectory queue.
module tb_gray_to_johnson_stepper;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_valid;
    logic [2:0] in_ready;
    logic [2:0] busy;
    logic [2:0] dir;
    logic [2:0] done;
    logic [2:0] gray_in [3];
    logic [3:0] jo      [3];
    logic [2:0] go      [3];

    int errors = 0;
    int checks = 0;
    int cur_idx  [3];
    int last_dir [3];

    typedef struct {
        logic [3:0] j;
        logic       done;
        logic       busy;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    gray_to_johnson_stepper #(.STEP_MODE("SHORTEST"), .DWELL(0)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .gray_in(gray_in[0]), .johnson_out(jo[0]), .gray_out(go[0]),
        .busy(busy[0]), .dir(dir[0]), .done(done[0]));

    gray_to_johnson_stepper #(.STEP_MODE("FORWARD"), .DWELL(0)) dut_f (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .gray_in(gray_in[1]), .johnson_out(jo[1]), .gray_out(go[1]),
        .busy(busy[1]), .dir(dir[1]), .done(done[1]));

    gray_to_johnson_stepper #(.STEP_MODE("SHORTEST"), .DWELL(2)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .gray_in(gray_in[2]), .johnson_out(jo[2]), .gray_out(go[2]),
        .busy(busy[2]), .dir(dir[2]), .done(done[2]));

    function automatic logic [3:0] jcode(input int p);
        case (p)
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0011;
            3: return 4'b0111;
            4: return 4'b1111;
            5: return 4'b1110;
            6: return 4'b1100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [2:0] gcode(input int p);
        case (p)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b011;
            3: return 3'b010;
            4: return 3'b110;
            5: return 3'b111;
            6: return 3'b101;
            default: return 3'b100;
        endcase
    endfunction

    function automatic int dwell_of(input int u);
        return (u == 2) ? 2 : 0;
    endfunction

    // Issues one command on instance u, pushes the expected per-cycle trajectory,
    // then pops and compares one entry per cycle. Called from inside a cycle.
    task automatic run_cmd(input int u, input int tgt, input bit chain, input bit poke);
        int   fwd, d, dirx, last, pos, dw;
        exp_t e;
        dw   = dwell_of(u);
        fwd  = (tgt - cur_idx[u] + 8) % 8;
        pos  = cur_idx[u];
        dirx = last_dir[u];
        if (fwd == 0) begin
            last = 1;
            for (int c = 0; c <= last; c++) begin
                e.j = jcode(pos); e.done = (c == last); e.busy = 1'b0;
                sbq.push_back(e);
            end
        end else begin
            dirx = (u == 1 || fwd <= 4) ? 1 : 0;
            d    = dirx ? fwd : 8 - fwd;
            last = 1 + (d - 1) * (dw + 1);
            for (int c = 0; c <= last; c++) begin
                if (c >= 1 && ((c - 1) % (dw + 1)) == 0)
                    pos = dirx ? (pos + 1) % 8 : (pos + 7) % 8;
                e.j = jcode(pos); e.done = (c == last); e.busy = (c < last);
                sbq.push_back(e);
            end
        end
        in_valid[u] = 1'b1;
        gray_in[u]  = gcode(tgt);
        @(posedge clk);
        @(negedge clk);
        in_valid[u] = 1'b0;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            e = sbq.pop_front();
            checks += 3;
            if (jo[u] !== e.j) begin
                errors++;
                $display("FAIL johnson u%0d tgt%0d c%0d: got %b want %b", u, tgt, c, jo[u], e.j);
            end
            if (done[u] !== e.done) begin
                errors++;
                $display("FAIL done u%0d tgt%0d c%0d: got %b want %b", u, tgt, c, done[u], e.done);
            end
            if (busy[u] !== e.busy) begin
                errors++;
                $display("FAIL busy u%0d tgt%0d c%0d: got %b want %b", u, tgt, c, busy[u], e.busy);
            end
            if (poke && c == 1) begin
                in_valid[u] = 1'b1;
                gray_in[u]  = gcode((tgt + 3) % 8);
            end
            if (poke && c == 2) in_valid[u] = 1'b0;
        end
        checks += 3;
        if (dir[u] !== 1'(dirx)) begin
            errors++;
            $display("FAIL dir u%0d tgt%0d: got %b want %0d", u, tgt, dir[u], dirx);
        end
        if (go[u] !== gcode(tgt)) begin
            errors++;
            $display("FAIL gray_out u%0d tgt%0d: got %b want %b", u, tgt, go[u], gcode(tgt));
        end
        if (in_ready[u] !== 1'b1) begin
            errors++;
            $display("FAIL in_ready u%0d tgt%0d: got %b want 1", u, tgt, in_ready[u]);
        end
        cur_idx[u]  = tgt;
        last_dir[u] = dirx;
        if (!chain) begin
            @(negedge clk);
            checks++;
            if (done[u] !== 1'b0 || jo[u] !== jcode(tgt)) begin
                errors++;
                $display("FAIL settle u%0d tgt%0d: done %b j %b want 0 %b", u, tgt, done[u], jo[u], jcode(tgt));
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 3'b000;
        for (int u = 0; u < 3; u++) begin
            gray_in[u] = 3'b000; cur_idx[u] = 0; last_dir[u] = 1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (jo[u] !== 4'b0000 || go[u] !== 3'b000 || busy[u] !== 1'b0 ||
                done[u] !== 1'b0 || dir[u] !== 1'b1 || in_ready[u] !== 1'b1) begin
                errors++;
                $display("FAIL reset u%0d: got j%b g%b busy%b done%b dir%b rdy%b want 0000 000 0 0 1 1",
                         u, jo[u], go[u], busy[u], done[u], dir[u], in_ready[u]);
            end
        end
    endtask

    task automatic test_shortest;
        run_cmd(0, 4, 1'b0, 1'b0);   // 0000 -> 1111, tie goes forward
        run_cmd(0, 0, 1'b0, 1'b0);   // through the wrap
        run_cmd(0, 7, 1'b0, 1'b0);   // one backward step
        run_cmd(0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_zero_distance;
        run_cmd(0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_forward_mode;
        run_cmd(1, 7, 1'b0, 1'b0);
    endtask

    task automatic test_dwell;
        run_cmd(2, 2, 1'b0, 1'b1);   // poke in_valid while busy
    endtask

    task automatic test_back_to_back;
        int t;
        for (int i = 0; i < 6; i++) begin
            t = int'($urandom_range(0, 7));
            run_cmd(0, t, (i < 5), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            t = int'($urandom_range(0, 7));
            run_cmd(2, t, (i < 3), 1'b0);
        end
    endtask

    task automatic test_reset_mid_move;
        // dut_f sits at p7; forward to p6 passes 0000, 0001, 0011 first.
        in_valid[1] = 1'b1;
        gray_in[1]  = gcode(6);
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (jo[1] !== 4'b0011 || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got j%b busy%b want 0011 1", jo[1], busy[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (jo[1] !== 4'b0000 || busy[1] !== 1'b0 || done[1] !== 1'b0 ||
            in_ready[1] !== 1'b1 || go[1] !== 3'b000 || dir[1] !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got j%b busy%b done%b rdy%b g%b dir%b want 0000 0 0 1 000 1",
                     jo[1], busy[1], done[1], in_ready[1], go[1], dir[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            cur_idx[u] = 0; last_dir[u] = 1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done[1] !== 1'b0 || jo[1] !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset c%0d: got done%b j%b want 0 0000", i, done[1], jo[1]);
            end
        end
        run_cmd(1, 3, 1'b0, 1'b0);
        run_cmd(0, 5, 1'b0, 1'b0);   // fwd 5 -> backward 3 steps
    endtask

    initial begin
        test_reset();
        test_shortest();
        test_zero_distance();
        test_forward_mode();
        test_dwell();
        test_back_to_back();
        test_reset_mid_move();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
